mcpu_mem_avl_ram_responder: RTL

Synthesizable Avalon-MM burst responder that sits on the memory-controller side of the ltc2mc_avl_*_0 interface, standing in for the DDR controller. Accepts read and write bursts from MCPU_MEM_ltc and backs them with on-chip block RAM. Returns read data with a fixed, parameterised latency. Used in cache/arbiter benches and FPGA bring-up without the hard memory controller.

---
 rtl/mcpu_mem_avl_pkg.sv | 15 +
 rtl/mcpu_mem_avl_bram.sv | 22 ++
 rtl/mcpu_mem_avl_ram_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_mem_avl_pkg.sv
// Shared widths and FSM encoding for the Avalon-MM block-RAM responder.
package mcpu_mem_avl_pkg;

  localparam int AVL_ADDR_W = 25;
  localparam int AVL_DATA_W = 128;
  localparam int AVL_BE_W   = 16;
  localparam int AVL_SIZE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WBURST = 2'd1,
    ST_RBURST = 2'd2
  } avl_state_e;

endpackage

// File: rtl/mcpu_mem_avl_bram.sv
// Single-port beat RAM with per-byte write enables and a registered read port.
module mcpu_mem_avl_bram
  import mcpu_mem_avl_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [AVL_BE_W-1:0]   we,
  input  logic [AVL_DATA_W-1:0] wdata,
  output logic [AVL_DATA_W-1:0] q
);

  logic [AVL_BE_W-1:0][7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < AVL_BE_W; b++)
      if (we[b]) mem[addr][b] <= wdata[b*8 +: 8];
    q <= mem[addr];
  end

endmodule

// File: rtl/mcpu_mem_avl_ram_responder.sv
// Avalon-MM burst responder backed by on-chip RAM; stands in for the DDR
// controller with fixed read latency and optional ready-gap stall injection.
module mcpu_mem_avl_ram_responder
  import mcpu_mem_avl_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 4,
  parameter int READY_GAP    = 0
) (
  input  logic                  clkrst_mem_clk,
  input  logic                  clkrst_mem_rst_n,
  input  logic [AVL_ADDR_W-1:0] ltc2mc_avl_addr_0,
  input  logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0,
  input  logic                  ltc2mc_avl_burstbegin_0,
  input  logic                  ltc2mc_avl_read_req_0,
  input  logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0,
  input  logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0,
  input  logic                  ltc2mc_avl_write_req_0,
  output logic                  ltc2mc_avl_ready_0,
  output logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0,
  output logic                  ltc2mc_avl_rdata_valid_0,
  output logic                  avl_err
);

  localparam int GAP_W = $clog2(READY_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(READY_GAP);

  avl_state_e            state, state_nxt;
  logic [ADDR_BITS-1:0]  ptr, ptr_nxt, ram_addr, cmd_addr;
  logic [AVL_SIZE_W-1:0] rem, rem_nxt, size_eff;
  logic [GAP_W-1:0]      gap, gap_nxt;
  logic                  ready, ready_nxt, err, err_nxt;
  logic                  ram_we, issue, req, rd, wr, bb;
  logic [AVL_DATA_W-1:0] ram_q, rdata_raw;
  logic [READ_LATENCY:1] vld_pipe;
  logic                  addr_unused;

  assign rd          = ltc2mc_avl_read_req_0;
  assign wr          = ltc2mc_avl_write_req_0;
  assign bb          = ltc2mc_avl_burstbegin_0;
  assign req         = rd | wr;
  assign cmd_addr    = ltc2mc_avl_addr_0[ADDR_BITS-1:0];
  assign addr_unused = ^ltc2mc_avl_addr_0[AVL_ADDR_W-1:ADDR_BITS];
  assign size_eff    = (ltc2mc_avl_size_0 == '0) ? AVL_SIZE_W'(1) : ltc2mc_avl_size_0;

  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
      gap   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      rem   <= rem_nxt;
      gap   <= gap_nxt;
      ready <= ready_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rem_nxt   = rem;
    err_nxt   = err;
    gap_nxt   = (gap != '0) ? gap - 1'b1 : gap;
    ram_addr  = ptr;
    ram_we    = 1'b0;
    issue     = 1'b0;
    // Illegal commands are dropped whole: no RAM access, no state change.
    if ((req && !ready) || (rd && wr)) begin
      err_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr && !bb) begin
            err_nxt = 1'b1;
          end else if (req && bb) begin
            ram_we   = wr;
            issue    = rd;
            ram_addr = cmd_addr;
            ptr_nxt  = cmd_addr + 1'b1;
            rem_nxt  = size_eff - 1'b1;
            if (ltc2mc_avl_size_0 == '0) err_nxt = 1'b1;
            if (size_eff == AVL_SIZE_W'(1)) gap_nxt = GAP_LOAD;
            else state_nxt = wr ? ST_WBURST : ST_RBURST;
          end
        end
        ST_WBURST: begin
          if (rd || bb) begin
            err_nxt = 1'b1;
          end else if (wr) begin
            ram_we  = 1'b1;
            ptr_nxt = ptr + 1'b1;
            rem_nxt = rem - 1'b1;
            if (rem == AVL_SIZE_W'(1)) begin
              state_nxt = ST_IDLE;
              gap_nxt   = GAP_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
    // Read bursts self-sequence one beat per cycle regardless of the bus.
    if (state == ST_RBURST) begin
      issue   = 1'b1;
      ptr_nxt = ptr + 1'b1;
      rem_nxt = rem - 1'b1;
      if (rem == AVL_SIZE_W'(1)) begin
        state_nxt = ST_IDLE;
        gap_nxt   = GAP_LOAD;
      end
    end
    ready_nxt = (state_nxt != ST_RBURST) && (gap_nxt == '0);
  end

  mcpu_mem_avl_bram #(.ADDR_BITS(ADDR_BITS)) u_bram (
    .clk   (clkrst_mem_clk),
    .addr  (ram_addr),
    .we    (ltc2mc_avl_be_0 & {AVL_BE_W{ram_we}}),
    .wdata (ltc2mc_avl_wdata_0),
    .q     (ram_q)
  );

  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // The RAM output register is the first latency stage; the rest is a shift pipe.
  generate
    if (READ_LATENCY > 1) begin : g_dly
      logic [READ_LATENCY-2:0][AVL_DATA_W-1:0] dly;
      always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
          dly <= '0;
        end else begin
          dly[0] <= ram_q;
          for (int i = 1; i < READ_LATENCY - 1; i++) dly[i] <= dly[i-1];
        end
      end
      assign rdata_raw = dly[READ_LATENCY-2];
    end else begin : g_nodly
      assign rdata_raw = ram_q;
    end
  endgenerate

  assign ltc2mc_avl_ready_0       = ready;
  assign ltc2mc_avl_rdata_valid_0 = vld_pipe[READ_LATENCY];
  assign ltc2mc_avl_rdata_0       = vld_pipe[READ_LATENCY] ? rdata_raw : '0;
  assign avl_err                  = err;

endmodule
